// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle right-shift/rotate unit.
//   - operation encodings for the mode input
//   - FSM state encoding
package shift_pkg;

    localparam logic [1:0] MODE_SRL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/rot_step.sv
// Combinational single-bit step of the shift/rotate unit.
// Ports:
//   acc      - current accumulator value
//   mode     - registered operation select (SRL / ROR / ROL / illegal)
//   acc_next - accumulator after one 1-bit step; illegal mode holds the value
module rot_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] acc_next
);

    always_comb begin
        acc_next = acc;
        case (mode)
            MODE_SRL: acc_next = {1'b0, acc[WIDTH-1:1]};
            MODE_ROR: acc_next = {acc[0], acc[WIDTH-1:1]};
            MODE_ROL: acc_next = {acc[WIDTH-2:0], acc[WIDTH-1]};
            default:  acc_next = acc;
        endcase
    end

endmodule

// File: rtl/seq_rotate_unit.sv
// Multi-cycle SRL/ROR/ROL unit, one bit per clock, start/busy/done handshake.
// Ports:
//   clk, rst_n - clock (rising edge), asynchronous active-low reset
//   start      - request, accepted only in IDLE or DONE
//   data_in    - operand, captured on an accepted start
//   shamt      - shift amount, captured on an accepted start
//   mode       - 00 SRL, 01 ROR, 10 ROL, 11 illegal (operand passes through, err set)
//   busy       - high while shifting
//   done       - one-cycle pulse, result valid
//   data_out   - result, held until the next result is produced
//   zero       - data_out == 0
//   err        - result came from an illegal mode
module seq_rotate_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] shamt,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             zero,
    output logic             err
);

    state_t           state, state_d;
    logic [WIDTH-1:0] acc, acc_step;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       mode_q;
    logic             load;

    // A start in SHIFT is dropped, not queued.
    assign load = start && (state != ST_SHIFT);

    rot_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .mode     (mode_q),
        .acc_next (acc_step)
    );

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt == '0) state_d = ST_DONE;
            ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            cnt      <= '0;
            mode_q   <= MODE_SRL;
            data_out <= '0;
            zero     <= 1'b1;
            err      <= 1'b0;
        end else if (load) begin
            acc    <= data_in;
            cnt    <= shamt;
            mode_q <= mode;
        end else if (state == ST_SHIFT) begin
            if (cnt != '0) begin
                acc <= acc_step;
                cnt <= cnt - CNT_W'(1);
            end else begin
                // Result registers move only on the edge entering DONE.
                data_out <= acc;
                zero     <= (acc == '0);
                err      <= (mode_q == MODE_ILL);
            end
        end
    end

    // Decoded from the registered state, so glitch-free.
    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule
